// File: rtl/delay_line_pkg.sv
// Shared types and default widths for the delay-line controller.
// The optional zero-fill output is selected by DELAY_FILL_ZERO_EN in delay_line_ctrl.
package delay_line_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 9;
    localparam int DEFAULT_DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } dl_state_e;

endpackage

// File: rtl/delay_line_ctrl_wrap_ptr.sv
// Wrap-around pointer: counts up by one per increment and rolls over naturally
// at 2^WIDTH; clear and reset both force it back to zero.
module wrap_ptr #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line controller driving an external dual-port RAM as a circular buffer.
// Define DELAY_FILL_ZERO_EN to emit a zero output for every sample taken before RUN.
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    input  logic                     flush,
    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [1:0]               state_o
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_RUN  = RUN;

    logic [1:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_d_lat;
    logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
    logic                     r_out_valid;

    logic                     w_accept;
    logic                     w_rd_en;
    logic [ADDRESS_WIDTH-1:0] w_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] w_delay_clamped;
    logic [ADDRESS_WIDTH-1:0] w_fill_next;

    // A sample coinciding with flush or reset is dropped, so it never reaches the RAM.
    assign w_accept        = in_valid && !flush && !rst;
    assign w_rd_en         = w_accept && (r_state == ST_RUN);
    assign w_delay_clamped = (delay == '0) ? ADDRESS_WIDTH'(1) : delay;
    assign w_fill_next     = r_fill_cnt + ADDRESS_WIDTH'(1);

    wrap_ptr #(
        .WIDTH(ADDRESS_WIDTH)
    ) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_inc   (w_accept),
        .o_count (w_wr_ptr)
    );

    assign ram_wr_en   = w_accept;
    assign ram_wr_addr = w_wr_ptr;
    assign ram_din     = in_data;
    assign ram_rd_en   = w_rd_en;
    assign ram_rd_addr = w_wr_ptr - r_d_lat;
    assign state_o     = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_d_lat    <= ADDRESS_WIDTH'(1);
            r_fill_cnt <= '0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_fill_cnt <= '0;
        end else if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    r_d_lat    <= w_delay_clamped;
                    r_fill_cnt <= ADDRESS_WIDTH'(1);
                    r_state    <= (w_delay_clamped == ADDRESS_WIDTH'(1)) ? ST_RUN : ST_FILL;
                end
                ST_FILL: begin
                    r_fill_cnt <= w_fill_next;
                    if (w_fill_next == r_d_lat) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_fill_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DELAY_FILL_ZERO_EN
    logic r_out_zero;

    // Pre-RUN samples produce a zero output so the output stays one-for-one with input.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            r_out_zero  <= w_accept && (r_state != ST_RUN);
        end
    end

    assign out_data = r_out_zero ? '0 : ram_dout;
`else
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd_en;
        end
    end

    assign out_data = ram_dout;
`endif

    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl with a behavioural RAM, ADDRESS_WIDTH=4.
// Honours DELAY_FILL_ZERO_EN the same way the design does.
module tb_delay_line_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] delay = '0;
    logic          flush = 1'b0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_dout;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    state_o;

    logic [DW-1:0] mem [0:DEPTH-1];

    int checks = 0;
    int failures = 0;

    int mCount = 0;
    int mWrPtr = 0;
    int mDlat = 1;
    int mState = 0;
    logic [DW-1:0] hist [$];
    logic [DW-1:0] expQ [$];

    delay_line_ctrl #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .delay       (delay),
        .flush       (flush),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_din     (ram_din),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_dout    (ram_dout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of stimulus: check last edge's outputs, drive, check strobes, update model.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input int dly,
                                 input logic fl, input logic rs);
        logic          expValid;
        logic [DW-1:0] e;
        logic          accept;
        logic          expRd;
        int            effD;

        @(negedge clk);
        expValid = (expQ.size() != 0);
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
        if (expValid) begin
            e = expQ.pop_front();
            if (out_valid) checkOutput("out_data", {24'd0, out_data}, {24'd0, e});
        end
        checkOutput("state_o", {30'd0, state_o}, mState);

        in_valid = v;
        in_data  = d;
        delay    = AW'(dly);
        flush    = fl;
        rst      = rs;
        #1;

        accept = v && !fl && !rs;
        effD   = (mCount == 0) ? ((dly % DEPTH == 0) ? 1 : dly % DEPTH) : mDlat;
        expRd  = accept && (mCount >= effD);
        checkOutput("wr_en", {31'd0, ram_wr_en}, {31'd0, accept});
        checkOutput("rd_en", {31'd0, ram_rd_en}, {31'd0, expRd});
        if (accept) begin
            checkOutput("wr_addr", {28'd0, ram_wr_addr}, mWrPtr);
            checkOutput("din", {24'd0, ram_din}, {24'd0, d});
        end
        if (expRd) checkOutput("rd_addr", {28'd0, ram_rd_addr}, (mWrPtr - effD + DEPTH) % DEPTH);

        if (rs || fl) begin
            mCount = 0;
            mWrPtr = 0;
            if (rs) mDlat = 1;
            hist.delete();
            expQ.delete();
        end else if (accept) begin
            if (mCount == 0) mDlat = effD;
            if (mCount >= mDlat) expQ.push_back(hist[mCount - mDlat]);
`ifdef DELAY_FILL_ZERO_EN
            else expQ.push_back('0);
`endif
            hist.push_back(d);
            mCount++;
            mWrPtr = (mWrPtr + 1) % DEPTH;
        end
        mState = (mCount == 0) ? 0 : ((mCount < mDlat) ? 1 : 2);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, '0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 0, 1'b0, 1'b1);
        idleCycles(2);

        // Basic delay of 3
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, DW'(i), 3, 1'b0, 1'b0);
        idleCycles(2);

        // Flush mid-RUN with a sample that must be dropped, then delay 4
        applyStimulus(1'b1, 8'hAA, 3, 1'b1, 1'b0);
        for (int i = 10; i < 20; i++) applyStimulus(1'b1, DW'(i), 4, 1'b0, 1'b0);
        idleCycles(1);

        // Delay 0 behaves as delay 1
        applyStimulus(1'b0, '0, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd7, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd9, 0, 1'b0, 1'b0);
        idleCycles(1);

        // Wrap with delay 5 over 40 samples
        applyStimulus(1'b0, '0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, DW'($urandom_range(0, 255)), 5, 1'b0, 1'b0);
        idleCycles(1);

        // Gapped input with delay 2
        applyStimulus(1'b0, '0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus((i % 3) != 1, DW'(100 + i), 2, 1'b0, 1'b0);
        idleCycles(1);

        // Reset after 2 of 6 fill samples
        applyStimulus(1'b0, '0, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd50, 6, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd51, 6, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd52, 6, 1'b0, 1'b1);
        idleCycles(1);

        // Maximum delay 2^AW-1
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(200 + i), DEPTH - 1, 1'b0, 1'b0);
        idleCycles(3);

        checkOutput("drain", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 The block SHALL provide parameter ADDRESS_WIDTH, default 9, which is the width of the RAM address bus and of the delay value.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 8, which is the sample width.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic SHALL be clocked on posedge clk.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  one new input sample this cycle.
REQ-006 The block SHALL have port in_data  input  DATA_WIDTH  input sample.
REQ-007 The block SHALL have port delay  input  ADDRESS_WIDTH  requested delay in samples.
REQ-008 The block SHALL have port flush  input  1  synchronous restart request.
REQ-009 The block SHALL have port ram_wr_en  output  1  write strobe to the downstream dual-port RAM.
REQ-010 The block SHALL have port ram_wr_addr  output  ADDRESS_WIDTH  RAM write address.
REQ-011 The block SHALL have port ram_din  output  DATA_WIDTH  RAM write data.
REQ-012 The block SHALL have port ram_rd_en  output  1  RAM read strobe.
REQ-013 The block SHALL have port ram_rd_addr  output  ADDRESS_WIDTH  RAM read address.
REQ-014 The block SHALL have port ram_dout  input  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_en.
REQ-015 The block SHALL have port out_valid  output  1  out_data carries a delayed sample.
REQ-016 The block SHALL have port out_data  output  DATA_WIDTH  delayed sample.
REQ-017 The block SHALL have port state_o  output  2  current FSM state, for debug.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, FILL and RUN.
REQ-019 In IDLE, a cycle with in_valid=1 SHALL latch delay into d_lat (0 clamped to 1), write the sample, set fill_cnt to 1, and go to FILL; if d_lat=1, the FSM SHALL instead go directly to RUN.
REQ-020 In FILL, each in_valid SHALL write the sample and increment fill_cnt; when fill_cnt reaches d_lat, the FSM SHALL go to RUN.
REQ-021 In RUN, each in_valid SHALL assert ram_wr_en and ram_rd_en in the same cycle, with ram_rd_addr = (wr_ptr - d_lat) mod 2^ADDRESS_WIDTH.
REQ-022 Every write SHALL drive ram_wr_addr=wr_ptr and ram_din=in_data; wr_ptr SHALL then increment, wrapping from 2^ADDRESS_WIDTH-1 to 0.
REQ-023 The RAM strobes SHALL be combinational from in_valid and state; no strobe SHALL be asserted in a cycle with in_valid=0.
REQ-024 out_valid SHALL be ram_rd_en delayed by one cycle (registered), and out_data SHALL equal ram_dout, giving a total latency of d_lat samples plus 1 clock.
REQ-025 The delay input SHALL be ignored outside IDLE; a new delay SHALL take effect only after flush or rst.
REQ-026 flush=1 SHALL return the FSM to IDLE, zero wr_ptr and fill_cnt, and clear out_valid on the next edge; an in_valid arriving in the same cycle SHALL be dropped.
REQ-027 Because d_lat >= 1, read and write addresses SHALL never collide in the same cycle.
REQ-028 When delay >= 2^ADDRESS_WIDTH-1 it SHALL be used as is, with maximum delay 2^ADDRESS_WIDTH-1.

Reset
REQ-029 On rst, the block SHALL enter IDLE, set wr_ptr=0, fill_cnt=0, d_lat=1, and out_valid=0.
REQ-030 rst SHALL take priority over flush and in_valid, including when asserted mid-FILL or mid-RUN.
REQ-031 While in reset, all RAM strobes SHALL be 0.

Configuration
REQ-032 The block SHALL support the macro DELAY_FILL_ZERO_EN.
REQ-033 With DELAY_FILL_ZERO_EN defined, each in_valid accepted in IDLE or FILL SHALL produce out_valid=1 with out_data=0 one cycle later, so the output stream is one-for-one with the input from the first sample.
REQ-034 Without DELAY_FILL_ZERO_EN, no output SHALL be produced before RUN.

Structure
REQ-035 Package delay_line_pkg SHALL hold the state enum typedef (IDLE=0, FILL=1, RUN=2) and the default width constants.
REQ-036 There SHALL be one sub-module, wrap_ptr: a parameterised wrap-around counter with increment and clear, used for wr_ptr.
REQ-037 The RAM SHALL remain external to this block.

Verification
REQ-038 Basic delay: delay=3, samples 1,2,3,4,5 on consecutive cycles -> RAM reads start at the 4th sample; out_data is 1 then 2, one clock after the 4th and 5th inputs.
REQ-039 Wrap: ADDRESS_WIDTH=4, delay=5, 40 samples -> wr_addr wraps 15->0, and rd_addr = wr_addr-5 mod 16 throughout with output unchanged.
REQ-040 Delay 0: delay=0, sample 7 then sample 9 -> behaves as delay 1; out_data=7 one clock after the sample 9 input.
REQ-041 Gapped input: delay=2 with in_valid toggling -> no strobes on idle cycles, and the output sequence equals the input shifted by 2.
REQ-042 Flush mid-RUN: flush with in_valid=1 -> that sample is not written, next cycle is IDLE with wr_ptr=0, and a new delay=4 takes effect.
REQ-043 Reset mid-FILL: rst after 2 of 6 fill samples -> all outputs 0 and state_o=IDLE the next cycle; DELAY_FILL_ZERO_EN builds emit zeros during fill.
